// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU memory blocks.
//   bypass_mode_e : collision handling mode (read-old / write-first)
//   strb_to_mask  : expands a byte strobe into a per-bit write mask
package npu_mem_pkg;

    typedef enum logic {
        BYPASS_READ_OLD    = 1'b0,
        BYPASS_WRITE_FIRST = 1'b1
    } bypass_mode_e;

    // Widest data path the mask helper supports (1024 bits).
    localparam int unsigned MAX_STRB_W = 128;
    localparam int unsigned MAX_DATA_W = MAX_STRB_W * 8;

    function automatic logic [MAX_DATA_W-1:0] strb_to_mask(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_STRB_W; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read response pipeline of depth RD_LAT: carries valid, collision flag and
// data from the launch cycle to the output.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   vld_i, coll_i : launch valid and collision flag
//   data_i        : read data decided in the launch cycle
//   vld_o, coll_o, data_o : registered response after RD_LAT cycles
module sram_rd_pipe #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vld_i,
    input  logic              coll_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic              coll_o,
    output logic [DATA_W-1:0] data_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] coll_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    // Data stages load only with a valid beat, so the output holds the last
    // returned word between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            coll_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= vld_i;
            coll_q[0] <= vld_i && coll_i;
            if (vld_i) begin
                data_q[0] <= data_i;
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                coll_q[i] <= coll_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign coll_o = coll_q[RD_LAT-1];
    assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/sram_dp_bw.sv
// Simple dual-port SRAM with byte-strobed writes and fixed-latency reads.
//   clk, rst                   : clock, asynchronous active-high reset
//   wen, waddr, wdata, wstrb   : write port (byte strobes, out-of-range ignored)
//   ren, raddr                 : read request (one per cycle, no backpressure)
//   rdata, rvalid              : read response, RD_LAT cycles after ren
//   coll                       : same-cycle read/write address collision flag
module sram_dp_bw
    import npu_mem_pkg::*;
#(
    parameter  int unsigned DATA_W = 128,
    parameter  int unsigned DEPTH  = 1024,
    parameter  int unsigned RD_LAT = 1,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              coll
);

    localparam bypass_mode_e    MODE    = bypass_mode_e'(BYPASS[0]);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [MAX_STRB_W-1:0] strb_ext;
    // Only the low DATA_W bits of the wide mask are used.
    logic [MAX_DATA_W-1:0] mask_wide_unused;
    logic [DATA_W-1:0]     wmask;
    logic [DATA_W-1:0]     rd_old;
    logic [DATA_W-1:0]     rd_data_d;
    logic                  wr_ok;
    logic                  rd_in_range;
    logic                  launch_d;
    logic                  coll_d;

    always_comb begin
        strb_ext               = '0;
        strb_ext[STRB_W-1:0]   = wstrb;
        mask_wide_unused       = strb_to_mask(strb_ext);
        wmask                  = mask_wide_unused[DATA_W-1:0];

        wr_ok       = !rst && wen && (|wstrb) && ({1'b0, waddr} < DEPTH_X);
        launch_d    = !rst && ren;
        rd_in_range = {1'b0, raddr} < DEPTH_X;
        rd_old      = rd_in_range ? mem[raddr] : '0;
        coll_d      = launch_d && wen && (|wstrb) && (waddr == raddr);

        rd_data_d = rd_old;
        if (coll_d && rd_in_range && MODE == BYPASS_WRITE_FIRST) begin
            rd_data_d = (rd_old & ~wmask) | (wdata & wmask);
        end
    end

    // Array is not reset; write is byte-enabled to map onto a macro.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i  (clk),
        .rst_i  (rst),
        .vld_i  (launch_d),
        .coll_i (coll_d),
        .data_i (rd_data_d),
        .vld_o  (rvalid),
        .coll_o (coll),
        .data_o (rdata)
    );

endmodule

// File: tb/tb_sram_dp_bw.sv
// Bench for sram_dp_bw: two instances share the stimulus
//   a: RD_LAT=1, write-first bypass   b: RD_LAT=2, read-old
// with DEPTH=1000 to exercise non-power-of-2 address boundaries.
module tb_sram_dp_bw;

    localparam int DW  = 128;
    localparam int DEP = 1000;
    localparam int AW  = 10;
    localparam int SW  = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          wen   = 1'b0;
    logic          ren   = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;

    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, coll_a, coll_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_dp_bw #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .coll(coll_a));

    sram_dp_bw #(.DATA_W(DW), .DEPTH(DEP), .RD_LAT(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .coll(coll_b));

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Each cycle records what a read launched in that cycle must return;
    // an instance with latency L shows the record from L-1 cycles ago,
    // unless a reset occurred at or after that launch.
    logic [DW-1:0] mm [DEP];
    int            cyc = 0;
    int            last_rst = 0;
    logic          h_v  [8];
    logic          h_c  [8];
    logic [DW-1:0] h_wf [8];
    logic [DW-1:0] h_ro [8];
    logic          ev [2];
    logic          ec [2];
    logic [DW-1:0] ed [2];

    initial begin
        for (int i = 0; i < 8; i++) h_v[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0; ec[k] = 1'b0; ed[k] = '0;
        end
    end

    always @(posedge clk) begin
        int            idx, s, lat;
        logic [DW-1:0] old, mrg;
        logic          cl;
        cyc++;
        idx = cyc % 8;
        if (rst) begin
            h_v[idx] = 1'b0;
            last_rst = cyc;
            ed[0] = '0;
            ed[1] = '0;
        end else begin
            old = (raddr < DEP) ? mm[raddr] : '0;
            cl  = wen && ren && (waddr == raddr) && (wstrb != 0);
            mrg = old;
            if (cl && raddr < DEP)
                for (int b = 0; b < SW; b++)
                    if (wstrb[b]) mrg[8*b +: 8] = wdata[8*b +: 8];
            h_v[idx] = ren; h_c[idx] = cl; h_wf[idx] = mrg; h_ro[idx] = old;
            if (wen && waddr < DEP)
                for (int b = 0; b < SW; b++)
                    if (wstrb[b]) mm[waddr][8*b +: 8] = wdata[8*b +: 8];
        end
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 2;
            s   = cyc - lat + 1;
            if (!rst && s > last_rst && h_v[s % 8]) begin
                ev[k] = 1'b1;
                ec[k] = h_c[s % 8];
                ed[k] = (k == 0) ? h_wf[s % 8] : h_ro[s % 8];
            end else begin
                ev[k] = 1'b0;
                ec[k] = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, just after the active edge.
    always @(posedge clk) begin
        #2;
        chk("a_rvalid", DW'(rvalid_a), DW'(ev[0]));
        chk("a_coll",   DW'(coll_a),   DW'(ec[0]));
        chk("a_rdata",  rdata_a,       ed[0]);
        chk("b_rvalid", DW'(rvalid_b), DW'(ev[1]));
        chk("b_coll",   DW'(coll_b),   DW'(ec[1]));
        chk("b_rdata",  rdata_b,       ed[1]);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] pick();
        int r;
        r = $urandom_range(0, 19);
        return AW'((r < 12) ? r : 986 + r);
    endfunction

    initial begin
        logic [DW-1:0] pat;
        pat = {4{32'hC0FFEE99}};

        repeat (3) step();
        chk("rst_a_rvalid", DW'(rvalid_a), '0);
        chk("rst_a_rdata",  rdata_a,       '0);
        chk("rst_b_rvalid", DW'(rvalid_b), '0);
        chk("rst_b_coll",   DW'(coll_b),   '0);
        rst = 1'b0;

        // preload: addr*3 for 0..7, random elsewhere
        wen = 1'b1; wstrb = '1;
        for (int a = 0; a < DEP; a++) begin
            waddr = AW'(a);
            wdata = (a < 8) ? DW'(a * 3) : {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        wen = 1'b0;

        // streaming reads
        for (int k = 0; k <= 8; k++) begin
            ren = (k < 8); raddr = AW'(k);
            step();
            if (k < 8) begin
                chk("stream_a_v", DW'(rvalid_a), DW'(1));
                chk("stream_a_d", rdata_a, DW'(k * 3));
            end
            if (k >= 1) begin
                chk("stream_b_v", DW'(rvalid_b), DW'(1));
                chk("stream_b_d", rdata_b, DW'((k - 1) * 3));
            end
        end
        ren = 1'b0;

        // byte strobes
        wen = 1'b1; waddr = 10'd5; wdata = '1; wstrb = '1; step();
        wdata = {16{8'hAA}}; wstrb = 16'h0001; step();
        wen = 1'b0; ren = 1'b1; raddr = 10'd5; step();
        ren = 1'b0;
        chk("strb_a_v", DW'(rvalid_a), DW'(1));
        chk("strb_a_d", rdata_a, {{15{8'hFF}}, 8'hAA});
        step();
        chk("strb_b_d", rdata_b, {{15{8'hFF}}, 8'hAA});

        // collision
        wen = 1'b1; waddr = 10'd7; wdata = '0; wstrb = '1; step();
        wdata = DW'(16'h1234); wstrb = 16'h0003; ren = 1'b1; raddr = 10'd7; step();
        wen = 1'b0; ren = 1'b0;
        chk("coll_a_d", rdata_a, DW'(16'h1234));
        chk("coll_a_c", DW'(coll_a), DW'(1));
        step();
        chk("coll_b_v", DW'(rvalid_b), DW'(1));
        chk("coll_b_d", rdata_b, '0);
        chk("coll_b_c", DW'(coll_b), DW'(1));
        chk("coll_a_c_clr", DW'(coll_a), '0);

        // hold while idle
        wen = 1'b1; waddr = 10'd2; wdata = DW'(8'h55); wstrb = '1; step();
        wen = 1'b0; ren = 1'b1; raddr = 10'd2; step();
        ren = 1'b0;
        chk("hold_a_first", rdata_a, DW'(8'h55));
        wen = 1'b1; waddr = 10'd2; wdata = DW'(8'h66); step();
        wen = 1'b0;
        repeat (9) step();
        chk("hold_a_v", DW'(rvalid_a), '0);
        chk("hold_a_d", rdata_a, DW'(8'h55));
        chk("hold_b_d", rdata_b, DW'(8'h55));

        // reset mid-flight
        ren = 1'b1; raddr = 10'd3; step();
        ren = 1'b0; rst = 1'b1;
        step(); step();
        chk("mrst_b_v", DW'(rvalid_b), '0);
        chk("mrst_b_d", rdata_b, '0);
        chk("mrst_a_d", rdata_a, '0);
        rst = 1'b0;
        step(); step();
        chk("mrst_b_v2", DW'(rvalid_b), '0);
        ren = 1'b1; raddr = 10'd3; step();
        ren = 1'b0;
        chk("mrst_a_keep", rdata_a, DW'(9));
        step();
        chk("mrst_b_keep", rdata_b, DW'(9));

        // boundaries
        wen = 1'b1; waddr = 10'd999; wdata = pat; wstrb = '1; step();
        waddr = 10'd1000; wdata = '1; step();
        wen = 1'b0; ren = 1'b1; raddr = 10'd999; step();
        chk("bnd_last", rdata_a, pat);
        raddr = 10'd0; step();
        chk("bnd_addr0", rdata_a, '0);
        raddr = 10'd1000; step();
        ren = 1'b0;
        chk("bnd_oor_v", DW'(rvalid_a), DW'(1));
        chk("bnd_oor_d", rdata_a, '0);
        step();
        chk("bnd_oor_b", rdata_b, '0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 149) == 0);
            wen   = $urandom_range(0, 1) == 1;
            ren   = $urandom_range(0, 2) != 0;
            waddr = pick();
            raddr = ($urandom_range(0, 3) == 0) ? waddr : pick();
            wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            wstrb = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom());
            step();
        end
        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
